// File: rtl/cell_exerciser.sv
// cell_exerciser: sweeps all 64 input vectors of an OAI222 cell under test,
// waits SETTLE cycles per vector, compares the cell output against
// ~((A1|A2)&(B1|B2)&(C1|C2)) and tallies mismatches.
//
// Ports:
//   CK          clock, rising edge
//   RST         synchronous active-high reset
//   START       level; begins a sweep from idle
//   ABORT       level; stops a sweep in progress (wins over START in idle)
//   ZN_IN       output of the cell under test
//   VEC[5:0]    stimulus {A1,A2,B1,B2,C1,C2}
//   BUSY        sweep in progress
//   DONE        one-cycle pulse while in FINISH
//   ERR_CNT[6:0] mismatching vectors in current/last sweep
//   FAIL        ERR_CNT != 0
//   FIRST_FAIL[5:0] VEC at first mismatch
//
// state   | meaning
// --------+---------------------------------------------
// IDLE    | waiting for START; VEC/ERR_CNT/FIRST_FAIL hold
// DRIVE   | new vector applied, settle counter loaded
// WAIT    | settle counter counts down SETTLE cycles
// SAMPLE  | ZN_IN compared against golden value
// FINISH  | DONE high for one cycle
module cell_exerciser #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       CK,
  input  logic       RST,
  input  logic       START,
  input  logic       ABORT,
  input  logic       ZN_IN,
  output logic [5:0] VEC,
  output logic       BUSY,
  output logic       DONE,
  output logic [6:0] ERR_CNT,
  output logic       FAIL,
  output logic [5:0] FIRST_FAIL
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DRIVE  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

  logic [2:0] state, state_nxt;
  logic [3:0] settle_cnt, settle_cnt_nxt;
  logic [5:0] vec_nxt;
  logic [6:0] err_nxt;
  logic [5:0] first_fail_nxt;
  logic       golden;
  logic       mismatch;

  assign golden   = ~((VEC[5] | VEC[4]) & (VEC[3] | VEC[2]) & (VEC[1] | VEC[0]));
  assign mismatch = (state == S_SAMPLE) && (ZN_IN != golden);

  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    vec_nxt        = VEC;
    err_nxt        = ERR_CNT;
    first_fail_nxt = FIRST_FAIL;

    // The compare in SAMPLE is recorded even if ABORT arrives on the same edge.
    if (mismatch) begin
      err_nxt = ERR_CNT + 7'd1;
      if (ERR_CNT == 7'd0) first_fail_nxt = VEC;
    end

    case (state)
      S_IDLE: begin
        if (START && !ABORT) begin
          state_nxt      = S_DRIVE;
          vec_nxt        = 6'd0;
          err_nxt        = 7'd0;
          first_fail_nxt = 6'd0;
          settle_cnt_nxt = SETTLE_LD;
        end
      end
      S_DRIVE: begin
        state_nxt = (SETTLE_LD != 4'd0) ? S_WAIT : S_SAMPLE;
      end
      S_WAIT: begin
        settle_cnt_nxt = settle_cnt - 4'd1;
        // Terminal count at 1: the cycle the counter reaches 0 is spent in SAMPLE.
        if (settle_cnt <= 4'd1) state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (VEC == 6'd63) begin
          state_nxt = S_FINISH;
        end else begin
          state_nxt      = S_DRIVE;
          vec_nxt        = VEC + 6'd1;
          settle_cnt_nxt = SETTLE_LD;
        end
      end
      S_FINISH: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    if (ABORT && state != S_IDLE) begin
      state_nxt      = S_IDLE;
      vec_nxt        = VEC;
      settle_cnt_nxt = settle_cnt;
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state      <= S_IDLE;
      settle_cnt <= 4'd0;
      VEC        <= 6'd0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ERR_CNT    <= 7'd0;
      FAIL       <= 1'b0;
      FIRST_FAIL <= 6'd0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_cnt_nxt;
      VEC        <= vec_nxt;
      BUSY       <= (state_nxt != S_IDLE);
      DONE       <= (state_nxt == S_FINISH);
      ERR_CNT    <= err_nxt;
      FAIL       <= (err_nxt != 7'd0);
      FIRST_FAIL <= first_fail_nxt;
    end
  end

endmodule

// File: tb/tb_cell_exerciser.sv
// Bench for cell_exerciser: one instance with SETTLE=2, one with SETTLE=0,
// both driven by a behavioural OAI222 or a stuck-at cell model.
module tb_cell_exerciser;

  logic CK = 1'b0;
  logic RST;
  logic start2, abort2, zn2;
  logic start0, abort0, zn0;
  logic [5:0] vec2, ff2, vec0, ff0;
  logic [6:0] err2, err0;
  logic busy2, done2, fail2, busy0, done0, fail0;

  int mode;  // 0 = behavioural OAI222, 1 = stuck-at-0, 2 = stuck-at-1
  int n_cmp = 0;
  int n_bad = 0;

  always #5 CK = ~CK;

  cell_exerciser #(.SETTLE(2)) dut2 (
    .CK(CK), .RST(RST), .START(start2), .ABORT(abort2), .ZN_IN(zn2),
    .VEC(vec2), .BUSY(busy2), .DONE(done2), .ERR_CNT(err2), .FAIL(fail2),
    .FIRST_FAIL(ff2)
  );

  cell_exerciser #(.SETTLE(0)) dut0 (
    .CK(CK), .RST(RST), .START(start0), .ABORT(abort0), .ZN_IN(zn0),
    .VEC(vec0), .BUSY(busy0), .DONE(done0), .ERR_CNT(err0), .FAIL(fail0),
    .FIRST_FAIL(ff0)
  );

  function automatic logic oai222(input logic [5:0] v);
    return ~((v[5] | v[4]) & (v[3] | v[2]) & (v[1] | v[0]));
  endfunction

  always_comb begin
    zn2 = (mode == 0) ? oai222(vec2) : (mode == 2);
    zn0 = (mode == 0) ? oai222(vec0) : (mode == 2);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic set_start(input bit sel, input bit v);
    if (sel) start0 = v;
    else     start2 = v;
  endtask

  // Pulses START, then watches cycles 1..300 after the sampling edge.
  // START is re-driven high during cycles lo..hi.
  task automatic sweep(input bit sel, input int lo, input int hi,
                       output int done_cyc, output int busy_cnt, output int vec_c1);
    set_start(sel, 1'b1);
    tick();
    set_start(sel, 1'b0);
    done_cyc = 0;
    busy_cnt = 0;
    vec_c1   = -1;
    for (int c = 1; c <= 300; c++) begin
      if (c == 1) vec_c1 = sel ? vec0 : vec2;
      if (sel ? busy0 : busy2) busy_cnt++;
      if ((sel ? done0 : done2) && done_cyc == 0) done_cyc = c;
      set_start(sel, (c >= lo) && (c <= hi));
      tick();
    end
    set_start(sel, 1'b0);
  endtask

  task automatic chk_reset2(input string tag);
    chk({tag, "_vec"},  vec2,  0);
    chk({tag, "_busy"}, busy2, 0);
    chk({tag, "_done"}, done2, 0);
    chk({tag, "_err"},  err2,  0);
    chk({tag, "_fail"}, fail2, 0);
    chk({tag, "_ff"},   ff2,   0);
  endtask

  initial begin
    int dc, bc, v1, dones;
    RST = 1'b1; start2 = 0; abort2 = 0; start0 = 0; abort0 = 0; mode = 0;
    tick(); tick();
    RST = 1'b0;
    chk_reset2("rst");

    // Golden sweep, SETTLE=2
    mode = 0;
    sweep(1'b0, 0, -1, dc, bc, v1);
    chk("gold_done_cyc", dc, 257);
    chk("gold_busy_cnt", bc, 257);
    chk("gold_vec_c1",   v1, 0);
    chk("gold_err",      err2, 0);
    chk("gold_fail",     fail2, 0);
    chk("idle_vec_hold", vec2, 63);

    // Stuck-at-0
    mode = 1;
    sweep(1'b0, 0, -1, dc, bc, v1);
    chk("sa0_done_cyc", dc, 257);
    chk("sa0_err",      err2, 37);
    chk("sa0_ff",       ff2, 0);
    chk("sa0_fail",     fail2, 1);

    // Stuck-at-1
    mode = 2;
    sweep(1'b0, 0, -1, dc, bc, v1);
    chk("sa1_err",  err2, 27);
    chk("sa1_ff",   ff2, 'h15);
    chk("sa1_fail", fail2, 1);

    // Abort at cycle 40 (SAMPLE of vector 9), golden model
    mode = 0;
    start2 = 1; tick(); start2 = 0;
    for (int i = 1; i < 40; i++) tick();
    chk("abt_vec_c40", vec2, 9);
    abort2 = 1; tick(); abort2 = 0;
    chk("abt_busy", busy2, 0);
    chk("abt_vec",  vec2, 9);
    chk("abt_err",  err2, 0);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (done2) dones++;
      tick();
    end
    chk("abt_no_done", dones, 0);
    chk("abt_vec_hold", vec2, 9);

    // Abort on a mismatching SAMPLE still counts it: vectors 0..9 all mismatch
    mode = 1;
    start2 = 1; tick(); start2 = 0;
    for (int i = 1; i < 40; i++) tick();
    abort2 = 1; tick(); abort2 = 0;
    chk("abt_sa0_err",  err2, 10);
    chk("abt_sa0_ff",   ff2, 0);
    chk("abt_sa0_fail", fail2, 1);

    // Restart after abort: VEC begins again at 0
    mode = 0;
    sweep(1'b0, 0, -1, dc, bc, v1);
    chk("rest_vec_c1",   v1, 0);
    chk("rest_done_cyc", dc, 257);
    chk("rest_err",      err2, 0);

    // Reset at cycle 100
    mode = 1;
    start2 = 1; tick(); start2 = 0;
    for (int i = 1; i < 100; i++) tick();
    RST = 1; start2 = 1; tick(); RST = 0; start2 = 0;
    chk_reset2("midrst");

    // START held while busy is ignored
    mode = 0;
    sweep(1'b0, 5, 199, dc, bc, v1);
    chk("storm_done_cyc", dc, 257);
    chk("storm_busy_cnt", bc, 257);

    // START held through FINISH: idle at 258, new sweep busy from 259
    sweep(1'b0, 250, 258, dc, bc, v1);
    chk("rearm_done_cyc", dc, 257);
    chk("rearm_busy_cnt", bc, 299);
    abort2 = 1; tick(); abort2 = 0;
    chk("rearm_abt_busy", busy2, 0);

    // SETTLE=0 instance
    mode = 0;
    sweep(1'b1, 0, -1, dc, bc, v1);
    chk("s0_done_cyc", dc, 129);
    chk("s0_busy_cnt", bc, 129);
    chk("s0_err",      err0, 0);
    start0 = 1; abort0 = 1; tick();
    chk("s0_both_busy", busy0, 0);
    start0 = 0; abort0 = 0; tick();
    chk("s0_both_busy2", busy0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
